// File: rtl/mux_scan_sel_if.sv
`default_nettype none
// ============================================================================
// Module   : mux_scan_sel_if
// Brief    : Signal bundle for the scanning channel selector (inputs, control,
//            registered selection result).
// Revision : 1.0  initial release
// ============================================================================
interface mux_scan_sel_if #(
    parameter int NCH     = 16,
    parameter int DW      = 1,
    parameter int DWELL_W = 8
);
    localparam int SELW = $clog2(NCH);

    logic [NCH*DW-1:0]  in;
    logic               en;
    logic               mode;
    logic [SELW-1:0]    sel;
    logic [DWELL_W-1:0] dwell;
    logic [DW-1:0]      out;
    logic               out_valid;
    logic [SELW-1:0]    cur_sel;
    logic               wrap;
    logic               sel_err;

    modport master (
        output in, en, mode, sel, dwell,
        input  out, out_valid, cur_sel, wrap, sel_err
    );

    modport slave (
        input  in, en, mode, sel, dwell,
        output out, out_valid, cur_sel, wrap, sel_err
    );
endinterface
`default_nettype wire

// File: rtl/mux_scan_sel.sv
`default_nettype none
// ============================================================================
// Module   : mux_scan_sel
// Brief    : N-channel registered selector with MANUAL select and SCAN
//            round-robin (programmable dwell) modes.
// Revision : 1.0  initial release
// ============================================================================
module mux_scan_sel #(
    parameter int NCH     = 16,
    parameter int DW      = 1,
    parameter int DWELL_W = 8
) (
    input  wire logic       clk,
    input  wire logic       rst,
    mux_scan_sel_if.slave   bus
);
    localparam int SELW = $clog2(NCH);
    localparam logic [SELW-1:0]    c_last    = SELW'(NCH - 1);
    localparam logic [SELW-1:0]    c_sel_one = SELW'(1);
    localparam logic [DWELL_W-1:0] c_cnt_one = DWELL_W'(1);

    logic [DW-1:0]      w_ch [NCH];
    logic [SELW-1:0]    w_sel_next;
    logic [DWELL_W-1:0] w_cnt_next;
    logic               w_wrap;
    logic               w_err;
    logic               w_sel_ok;

    logic [DW-1:0]      r_out;
    logic               r_out_valid;
    logic [SELW-1:0]    r_cur_sel;
    logic [DWELL_W-1:0] r_cnt;
    logic               r_wrap;
    logic               r_sel_err;

    for (genvar k = 0; k < NCH; k++) begin : g_ch
        assign w_ch[k] = bus.in[k*DW +: DW];
    end

    assign w_sel_ok = (32'(bus.sel) < NCH);

    always_comb begin
        w_sel_next = r_cur_sel;
        w_cnt_next = '0;
        w_wrap     = 1'b0;
        w_err      = 1'b0;
        if (!bus.mode) begin
            if (w_sel_ok) begin
                w_sel_next = bus.sel;
            end else begin
                w_err = 1'b1;
            end
        end else if (r_cnt >= bus.dwell) begin
            // dwell is compared live, so lowering it below cnt forces an advance
            if (r_cur_sel == c_last) begin
                w_sel_next = '0;
                w_wrap     = 1'b1;
            end else begin
                w_sel_next = r_cur_sel + c_sel_one;
            end
        end else begin
            w_cnt_next = r_cnt + c_cnt_one;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out       <= '0;
            r_out_valid <= 1'b0;
            r_cur_sel   <= '0;
            r_cnt       <= '0;
            r_wrap      <= 1'b0;
            r_sel_err   <= 1'b0;
        end else if (bus.en) begin
            r_out       <= w_ch[w_sel_next];
            r_out_valid <= 1'b1;
            r_cur_sel   <= w_sel_next;
            r_cnt       <= w_cnt_next;
            r_wrap      <= w_wrap;
            r_sel_err   <= w_err;
        end else begin
            r_out_valid <= 1'b0;
            r_wrap      <= 1'b0;
            r_sel_err   <= 1'b0;
        end
    end

    assign bus.out       = r_out;
    assign bus.out_valid = r_out_valid;
    assign bus.cur_sel   = r_cur_sel;
    assign bus.wrap      = r_wrap;
    assign bus.sel_err   = r_sel_err;
endmodule
`default_nettype wire

// File: tb/tb_mux_scan_sel.sv
`default_nettype none
// ============================================================================
// Module   : tb_mux_scan_sel
// Brief    : Directed self-checking bench for mux_scan_sel (NCH = 16, 12, 4).
// Revision : 1.0  initial release
// ============================================================================
module tb_mux_scan_sel;
    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;

    mux_scan_sel_if #(.NCH(16), .DW(1), .DWELL_W(8)) b16 ();
    mux_scan_sel_if #(.NCH(12), .DW(1), .DWELL_W(8)) b12 ();
    mux_scan_sel_if #(.NCH(4),  .DW(1), .DWELL_W(8)) b4 ();

    mux_scan_sel #(.NCH(16), .DW(1), .DWELL_W(8)) u16 (.clk(clk), .rst(rst), .bus(b16));
    mux_scan_sel #(.NCH(12), .DW(1), .DWELL_W(8)) u12 (.clk(clk), .rst(rst), .bus(b12));
    mux_scan_sel #(.NCH(4),  .DW(1), .DWELL_W(8)) u4  (.clk(clk), .rst(rst), .bus(b4));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       en;
        logic [3:0] sel;
        logic       exp_out;
        logic [3:0] exp_sel;
        logic       exp_valid;
        logic       exp_err;
    } vec_t;

    vec_t vecs [17];

    task automatic chk(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [15:0] pat16;
        logic [3:0]  pat4;
        int          exp4 [15];

        n_checks = 0;
        n_errors = 0;
        rst = 1'b1;
        b16.en = 1'b0; b16.mode = 1'b0; b16.sel = '0; b16.dwell = '0; b16.in = 16'($urandom);
        b12.en = 1'b0; b12.mode = 1'b0; b12.sel = '0; b12.dwell = '0; b12.in = 12'($urandom);
        b4.en  = 1'b0; b4.mode  = 1'b0; b4.sel  = '0; b4.dwell  = '0; b4.in  = 4'($urandom);

        // Reset with enables asserted: reset must win
        b16.en = 1'b1; b12.en = 1'b1; b4.en = 1'b1;
        tick();
        b16.in = 16'($urandom);
        tick();
        chk("rst_out",     int'(b16.out), 0);
        chk("rst_valid",   int'(b16.out_valid), 0);
        chk("rst_cur_sel", int'(b16.cur_sel), 0);
        chk("rst_wrap",    int'(b16.wrap), 0);
        chk("rst_sel_err", int'(b16.sel_err), 0);
        chk("rst_cur12",   int'(b12.cur_sel), 0);
        chk("rst_cur4",    int'(b4.cur_sel), 0);
        b12.en = 1'b0; b4.en = 1'b0;
        rst = 1'b0;

        // MANUAL sweep on NCH=16, then one frozen cycle
        pat16 = 16'hA5C3;
        for (int i = 0; i < 16; i++)
            vecs[i] = '{1'b1, 4'(i), pat16[i], 4'(i), 1'b1, 1'b0};
        vecs[16] = '{1'b0, 4'd3, 1'b1, 4'd15, 1'b0, 1'b0};
        b16.in = pat16;
        b16.mode = 1'b0;
        for (int i = 0; i < 17; i++) begin
            b16.en  = vecs[i].en;
            b16.sel = vecs[i].sel;
            tick();
            chk($sformatf("man16_out[%0d]", i),   int'(b16.out),       int'(vecs[i].exp_out));
            chk($sformatf("man16_sel[%0d]", i),   int'(b16.cur_sel),   int'(vecs[i].exp_sel));
            chk($sformatf("man16_valid[%0d]", i), int'(b16.out_valid), int'(vecs[i].exp_valid));
            chk($sformatf("man16_err[%0d]", i),   int'(b16.sel_err),   int'(vecs[i].exp_err));
        end

        // MANUAL out-of-range select on NCH=12
        b12.in = 12'h0A5;
        b12.en = 1'b1; b12.mode = 1'b0; b12.sel = 4'd5;
        tick();
        chk("m12_sel5",   int'(b12.cur_sel), 5);
        chk("m12_out5",   int'(b12.out), 1);
        chk("m12_err0",   int'(b12.sel_err), 0);
        b12.sel = 4'd13;
        tick();
        chk("m12_hold",   int'(b12.cur_sel), 5);
        chk("m12_err1",   int'(b12.sel_err), 1);
        chk("m12_out_h",  int'(b12.out), 1);
        chk("m12_valid",  int'(b12.out_valid), 1);
        b12.sel = 4'd5;
        b12.in  = 12'h085;
        tick();
        chk("m12_errclr", int'(b12.sel_err), 0);
        chk("m12_data",   int'(b12.out), 0);

        // SCAN on NCH=4, dwell=2
        pat4 = 4'b0110;
        exp4 = '{0, 0, 1, 1, 1, 2, 2, 2, 3, 3, 3, 0, 0, 0, 1};
        b4.in = pat4; b4.mode = 1'b1; b4.dwell = 8'd2; b4.en = 1'b1;
        for (int i = 0; i < 15; i++) begin
            tick();
            chk($sformatf("scan4_sel[%0d]", i),  int'(b4.cur_sel), exp4[i]);
            chk($sformatf("scan4_out[%0d]", i),  int'(b4.out),     int'(pat4[exp4[i]]));
            chk($sformatf("scan4_wrap[%0d]", i), int'(b4.wrap),    (i == 11) ? 1 : 0);
            chk($sformatf("scan4_err[%0d]", i),  int'(b4.sel_err), 0);
        end

        // dwell=0 with a 3-cycle freeze
        b4.dwell = 8'd0;
        tick();
        chk("d0_sel2", int'(b4.cur_sel), 2);
        tick();
        chk("d0_sel3", int'(b4.cur_sel), 3);
        b4.en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("frz_sel[%0d]", i),   int'(b4.cur_sel), 3);
            chk($sformatf("frz_out[%0d]", i),   int'(b4.out), 0);
            chk($sformatf("frz_valid[%0d]", i), int'(b4.out_valid), 0);
            chk($sformatf("frz_wrap[%0d]", i),  int'(b4.wrap), 0);
        end
        b4.en = 1'b1;
        tick();
        chk("res_sel0",  int'(b4.cur_sel), 0);
        chk("res_wrap",  int'(b4.wrap), 1);
        chk("res_valid", int'(b4.out_valid), 1);
        tick();
        chk("res_sel1",  int'(b4.cur_sel), 1);
        chk("res_out1",  int'(b4.out), 1);
        chk("res_wrap0", int'(b4.wrap), 0);

        // NCH=16: MANUAL->SCAN from ch15, live dwell drop, reset mid-scan
        b16.en = 1'b1; b16.mode = 1'b1; b16.dwell = 8'd200;
        for (int i = 0; i < 100; i++) tick();
        chk("dw_hold15", int'(b16.cur_sel), 15);
        b16.dwell = 8'd10;
        tick();
        chk("dw_adv0",   int'(b16.cur_sel), 0);
        chk("dw_wrap",   int'(b16.wrap), 1);
        chk("dw_out0",   int'(b16.out), int'(pat16[0]));
        b16.dwell = 8'd0;
        for (int i = 0; i < 7; i++) tick();
        chk("dw_sel7",   int'(b16.cur_sel), 7);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mrst_sel",   int'(b16.cur_sel), 0);
        chk("mrst_wrap",  int'(b16.wrap), 0);
        chk("mrst_valid", int'(b16.out_valid), 0);
        chk("mrst_out",   int'(b16.out), 0);
        tick();
        chk("mrst_next",  int'(b16.cur_sel), 1);

        // SCAN->MANUAL honours sel immediately
        b16.dwell = 8'd50;
        tick();
        b16.mode = 1'b0; b16.sel = 4'd9;
        tick();
        chk("s2m_sel9", int'(b16.cur_sel), 9);
        chk("s2m_out9", int'(b16.out), int'(pat16[9]));

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
`default_nettype wire
